exp_adjust_pipe: RTL and testbench

//  Pipelined, parametrised exponent-adjust stage for the FP add/sub datapath, placed after LOPD/normalisation.

---
 rtl/exp_adjust_pipe.sv | 118 +++++++++++
 tb/tb_exp_adjust_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_adjust_pipe.sv
// Exponent-adjust stage for the FP add/sub datapath, placed after LOPD/normalise.
// Two-stage valid/ready pipe: stage 1 forms the raw exponent, stage 2 classifies it.
module exp_adjust_pipe #(
   parameter int SIZE_EXP  = 8,
   parameter int SIZE_LOPD = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_overflow,
   input  logic                 i_underflow,
   input  logic                 i_zero_flag,
   input  logic [SIZE_LOPD-1:0] i_lopd_value,
   input  logic [SIZE_EXP-1:0]  i_exp_value,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_EXP-1:0]  o_exp_result,
   output logic                 o_inf,
   output logic                 o_denorm,
   output logic                 o_zero,
   output logic [SIZE_LOPD:0]   o_rshift,
   input  logic                 i_flag_clr,
   output logic                 o_flag_ovf,
   output logic                 o_flag_unf
);
   localparam int RW  = SIZE_EXP + 2;
   localparam int RSW = SIZE_LOPD + 1;
   localparam logic signed [RW-1:0] INF_RAW = RW'((1 << SIZE_EXP) - 1);

   typedef struct packed {
      logic          zero;
      logic [RW-1:0] raw;
   } s1_t;

   typedef struct packed {
      logic [SIZE_EXP-1:0] exp;
      logic                inf;
      logic                denorm;
      logic                zero;
      logic [RSW-1:0]      rshift;
   } s2_t;

   logic [1:0]          vld_pipe;  // [0] stage 1, [1] stage 2
   s1_t                 s1_d, s1_q;
   s2_t                 s2_d, s2_q;
   logic                adv1, adv2, xfer_out;
   logic signed [RW-1:0] exp_ext, lopd_ext, raw1;
   logic                flag_ovf, flag_unf;

   assign adv2     = ~vld_pipe[1] | i_ready;
   assign adv1     = ~vld_pipe[0] | adv2;
   assign xfer_out = vld_pipe[1] & i_ready;

   assign exp_ext  = {2'b00, i_exp_value};
   assign lopd_ext = {{(RW-SIZE_LOPD){1'b0}}, i_lopd_value};

   // Priority zero > overflow > underflow > normal; zero leaves raw unused.
   always_comb begin
      s1_d.zero = i_zero_flag;
      s1_d.raw  = '0;
      if (i_zero_flag)      s1_d.raw = '0;
      else if (i_overflow)  s1_d.raw = exp_ext + RW'(1);
      else if (i_underflow) s1_d.raw = exp_ext;
      else                  s1_d.raw = exp_ext - lopd_ext;
   end

   assign raw1 = s1_q.raw;

   // raw >= -(2^SIZE_LOPD-1), so 1-raw always fits in SIZE_LOPD+1 bits.
   always_comb begin
      s2_d = '0;
      if (s1_q.zero) begin
         s2_d.zero = 1'b1;
      end else if (raw1 >= INF_RAW) begin
         s2_d.exp = '1;
         s2_d.inf = 1'b1;
      end else if (raw1[RW-1] || raw1 == '0) begin
         s2_d.denorm = 1'b1;
         s2_d.rshift = RSW'(1) - raw1[SIZE_LOPD:0];
      end else begin
         s2_d.exp = raw1[SIZE_EXP-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         flag_ovf <= 1'b0;
         flag_unf <= 1'b0;
      end else begin
         if (adv1) begin
            vld_pipe[0] <= i_valid;
            if (i_valid) s1_q <= s1_d;
         end
         if (adv2) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) s2_q <= s2_d;
         end
         // A setting transfer wins over a simultaneous clear.
         flag_ovf <= (xfer_out & s2_q.inf)    | (flag_ovf & ~i_flag_clr);
         flag_unf <= (xfer_out & s2_q.denorm) | (flag_unf & ~i_flag_clr);
      end
   end

   assign o_ready      = adv1;
   assign o_valid      = vld_pipe[1];
   assign o_exp_result = s2_q.exp;
   assign o_inf        = s2_q.inf;
   assign o_denorm     = s2_q.denorm;
   assign o_zero       = s2_q.zero;
   assign o_rshift     = s2_q.rshift;
   assign o_flag_ovf   = flag_ovf;
   assign o_flag_unf   = flag_unf;

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// Bench for exp_adjust_pipe: directed corner cases plus randomized traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_exp_adjust_pipe;
   localparam int SE  = 8;
   localparam int SL  = 5;
   localparam int NTX = 300;

   logic          i_clk = 1'b0, i_rst_n = 1'b0;
   logic          i_valid = 1'b0, i_ready = 1'b1, i_flag_clr = 1'b0;
   logic          i_overflow = 1'b0, i_underflow = 1'b0, i_zero_flag = 1'b0;
   logic [SL-1:0] i_lopd_value = '0;
   logic [SE-1:0] i_exp_value = '0;
   logic          o_ready, o_valid, o_inf, o_denorm, o_zero, o_flag_ovf, o_flag_unf;
   logic [SE-1:0] o_exp_result;
   logic [SL:0]   o_rshift;

   typedef struct packed {
      logic [SE-1:0] res;
      logic          inf;
      logic          den;
      logic          zero;
      logic [SL:0]   rsh;
   } res_t;

   int   n_checks = 0, n_fail = 0, rd = 0;
   res_t pend_q[$], got_q[$], want_q[$];
   bit   m_ovf = 1'b0, m_unf = 1'b0;

   exp_adjust_pipe #(.SIZE_EXP(SE), .SIZE_LOPD(SL)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_overflow(i_overflow), .i_underflow(i_underflow), .i_zero_flag(i_zero_flag),
      .i_lopd_value(i_lopd_value), .i_exp_value(i_exp_value), .o_valid(o_valid),
      .i_ready(i_ready), .o_exp_result(o_exp_result), .o_inf(o_inf), .o_denorm(o_denorm),
      .o_zero(o_zero), .o_rshift(o_rshift), .i_flag_clr(i_flag_clr),
      .o_flag_ovf(o_flag_ovf), .o_flag_unf(o_flag_unf)
   );

   always #5 i_clk = ~i_clk;

   function automatic res_t model(bit ov, bit un, bit z, int lopd, int e);
      res_t r;
      int   raw;
      r = '0;
      if (z) begin
         r.zero = 1'b1;
         return r;
      end
      raw = ov ? e + 1 : (un ? e : e - lopd);
      if (raw >= (1 << SE) - 1) begin
         r.res = '1;
         r.inf = 1'b1;
      end else if (raw <= 0) begin
         r.den = 1'b1;
         r.rsh = (SL+1)'(1 - raw);
      end else begin
         r.res = SE'(raw);
      end
      return r;
   endfunction

   // Records transfers that will happen at the coming rising edge.
   always @(negedge i_clk) begin
      res_t w, g;
      bit   xo;
      if (!i_rst_n) begin
         pend_q.delete();
         m_ovf <= 1'b0;
         m_unf <= 1'b0;
      end else begin
         xo = o_valid && i_ready;
         w  = '0;
         if (xo) begin
            g = {o_exp_result, o_inf, o_denorm, o_zero, o_rshift};
            if (pend_q.size() > 0) w = pend_q.pop_front();
            else w = '{res: '0, inf: 1'b1, den: 1'b1, zero: 1'b1, rsh: '0};
            got_q.push_back(g);
            want_q.push_back(w);
         end
         m_ovf <= (xo && w.inf) || (m_ovf && !i_flag_clr);
         m_unf <= (xo && w.den) || (m_unf && !i_flag_clr);
         if (i_valid && o_ready)
            pend_q.push_back(model(i_overflow, i_underflow, i_zero_flag,
                                   int'(i_lopd_value), int'(i_exp_value)));
      end
   end

   task automatic drive(bit ov, bit un, bit z, int lopd, int e);
      i_overflow   = ov;
      i_underflow  = un;
      i_zero_flag  = z;
      i_lopd_value = SL'(lopd);
      i_exp_value  = SE'(e);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      i_rst_n = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      n_checks++;
      if ({o_exp_result, o_inf, o_denorm, o_zero, o_rshift} !== '0)
         begin n_fail++; $display("FAIL rst_outs: got %h %b%b%b %h want 0", o_exp_result, o_inf, o_denorm, o_zero, o_rshift); end
      n_checks++;
      if ({o_flag_ovf, o_flag_unf} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b%b want 00", o_flag_ovf, o_flag_unf); end
   endtask

   task automatic test_normal();
      drive(0, 0, 0, 3, 8'h80);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL normal_lat1: o_valid got %b want 0", o_valid); end
      step();
      n_checks++;
      if (o_valid !== 1'b1) begin n_fail++; $display("FAIL normal_lat2: o_valid got %b want 1", o_valid); end
      n_checks++;
      if ({o_exp_result, o_inf, o_denorm, o_zero, o_rshift} !== {8'h7D, 3'b000, 6'd0})
         begin n_fail++; $display("FAIL normal_res: got %h %b%b%b %0d want 7d 000 0", o_exp_result, o_inf, o_denorm, o_zero, o_rshift); end
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL normal_single: o_valid got %b want 0", o_valid); end
   endtask

   task automatic test_inf_flag();
      drive(1, 0, 0, 0, 8'hFE);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      step();
      n_checks++;
      if ({o_valid, o_exp_result, o_inf, o_denorm, o_zero} !== {1'b1, 8'hFF, 3'b100})
         begin n_fail++; $display("FAIL inf_res: got v%b %h %b%b%b want v1 ff 100", o_valid, o_exp_result, o_inf, o_denorm, o_zero); end
      n_checks++;
      if (o_flag_ovf !== 1'b0) begin n_fail++; $display("FAIL inf_flag_early: got %b want 0", o_flag_ovf); end
      step();
      n_checks++;
      if (o_flag_ovf !== 1'b1) begin n_fail++; $display("FAIL inf_flag_set: got %b want 1", o_flag_ovf); end
      repeat (3) step();
      n_checks++;
      if (o_flag_ovf !== 1'b1) begin n_fail++; $display("FAIL inf_flag_hold: got %b want 1", o_flag_ovf); end
      i_flag_clr = 1'b1;
      step();
      i_flag_clr = 1'b0;
      n_checks++;
      if (o_flag_ovf !== 1'b0) begin n_fail++; $display("FAIL inf_flag_clr: got %b want 0", o_flag_ovf); end
   endtask

   task automatic test_denorm_zero();
      drive(0, 0, 0, 5, 8'h02);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      step();
      n_checks++;
      if ({o_exp_result, o_inf, o_denorm, o_zero, o_rshift} !== {8'h00, 3'b010, 6'd4})
         begin n_fail++; $display("FAIL denorm_res: got %h %b%b%b %0d want 00 010 4", o_exp_result, o_inf, o_denorm, o_zero, o_rshift); end
      step();
      n_checks++;
      if (o_flag_unf !== 1'b1) begin n_fail++; $display("FAIL denorm_flag: got %b want 1", o_flag_unf); end
      drive(1, 0, 1, 0, 8'hFE);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      step();
      n_checks++;
      if ({o_exp_result, o_inf, o_denorm, o_zero, o_rshift} !== {8'h00, 3'b001, 6'd0})
         begin n_fail++; $display("FAIL zero_res: got %h %b%b%b %0d want 00 001 0", o_exp_result, o_inf, o_denorm, o_zero, o_rshift); end
      step();
      n_checks++;
      if ({o_flag_ovf, o_flag_unf} !== 2'b01) begin n_fail++; $display("FAIL zero_flags: got %b%b want 01", o_flag_ovf, o_flag_unf); end
   endtask

   task automatic test_set_over_clr();
      i_flag_clr = 1'b1;
      drive(1, 0, 0, 0, 8'hFF);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      step();
      step();
      n_checks++;
      if ({o_flag_ovf, o_flag_unf} !== 2'b10) begin n_fail++; $display("FAIL set_vs_clr: got %b%b want 10", o_flag_ovf, o_flag_unf); end
      step();
      i_flag_clr = 1'b0;
      n_checks++;
      if (o_flag_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_after_set: got %b want 0", o_flag_ovf); end
   endtask

   task automatic test_back_to_back();
      res_t ra;
      rd = got_q.size();
      ra = model(0, 0, 0, 2, 8'h40);
      i_ready = 1'b0;
      drive(0, 0, 0, 2, 8'h40);
      i_valid = 1'b1;
      step();
      drive(1, 0, 0, 0, 8'h10);
      step();
      drive(0, 1, 0, 7, 8'h33);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", k, o_ready); end
         n_checks++;
         if ({o_valid, o_exp_result} !== {1'b1, ra.res})
            begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h want v1 %h", k, o_valid, o_exp_result, ra.res); end
         step();
      end
      i_ready = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (4) step();
      n_checks++;
      if (got_q.size() - rd !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got_q.size() - rd); end
      while (rd < got_q.size()) begin
         n_checks++;
         if (got_q[rd] !== want_q[rd]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", rd, got_q[rd], want_q[rd]); end
         rd++;
      end
   endtask

   task automatic test_random();
      int  sent, c, e;
      bit  acc;
      rd = got_q.size();
      sent = 0;
      i_valid = 1'b0;
      for (c = 0; c < 4000 && sent < NTX; c++) begin
         @(negedge i_clk);
         acc = i_valid && o_ready;
         if (i_ready) begin
            n_checks++;
            if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want 1", c, o_ready); end
         end
         step();
         n_checks++;
         if ({o_flag_ovf, o_flag_unf} !== {m_ovf, m_unf})
            begin n_fail++; $display("FAIL rnd_flags c%0d: got %b%b want %b%b", c, o_flag_ovf, o_flag_unf, m_ovf, m_unf); end
         if (acc) sent++;
         if (!i_valid || acc) begin
            case ($urandom % 6)
               0: e = 0;
               1: e = 1;
               2: e = 2;
               3: e = 8'hFE;
               4: e = 8'hFF;
               default: e = int'($urandom % 256);
            endcase
            drive($urandom % 4 == 0, $urandom % 4 == 0, $urandom % 10 == 0, int'($urandom % 32), e);
            i_valid = (sent < NTX) && ($urandom % 4 != 0);
         end
         i_ready    = ($urandom % 3 != 0);
         i_flag_clr = ($urandom % 16 == 0);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_flag_clr = 1'b0;
      n_checks++;
      if (sent !== NTX) begin n_fail++; $display("FAIL rnd_timeout: sent %0d want %0d", sent, NTX); end
      for (int k = 0; k < 20 && (pend_q.size() > 0 || o_valid); k++) step();
      step();
      n_checks++;
      if (pend_q.size() !== 0) begin n_fail++; $display("FAIL rnd_lost: pending %0d want 0", pend_q.size()); end
      n_checks++;
      if (got_q.size() - rd !== NTX) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got_q.size() - rd, NTX); end
      while (rd < got_q.size()) begin
         n_checks++;
         if (got_q[rd] !== want_q[rd]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", rd, got_q[rd], want_q[rd]); end
         rd++;
      end
   endtask

   task automatic test_reset_midflight();
      res_t rd_exp;
      rd_exp = model(0, 1, 0, 9, 8'h10);
      i_ready = 1'b1;
      drive(1, 0, 0, 0, 8'hFF);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (3) step();
      n_checks++;
      if (o_flag_ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre_flag: got %b want 1", o_flag_ovf); end
      i_ready = 1'b0;
      drive(0, 0, 0, 1, 8'h20);
      i_valid = 1'b1;
      step();
      drive(0, 0, 0, 1, 8'h30);
      step();
      i_valid = 1'b0;
      n_checks++;
      if ({o_valid, o_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_full: got v%b r%b want v1 r0", o_valid, o_ready); end
      #2;
      i_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_flag_ovf, o_flag_unf} !== 3'b000)
         begin n_fail++; $display("FAIL mid_async: got v%b f%b%b want v0 f00", o_valid, o_flag_ovf, o_flag_unf); end
      @(negedge i_clk);
      step();
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", o_ready); end
      drive(0, 1, 0, 9, 8'h10);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: got %b want 0", o_valid); end
      step();
      n_checks++;
      if ({o_valid, o_exp_result, o_inf, o_denorm, o_zero} !== {1'b1, rd_exp.res, 3'b000})
         begin n_fail++; $display("FAIL mid_first: got v%b %h want v1 %h", o_valid, o_exp_result, rd_exp.res); end
      step();
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", o_valid); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_inf_flag();
      test_denorm_zero();
      test_set_over_clr();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
